ps2_command_sequencer: RTL and testbench

PS2_COMMAND_SEQUENCER -- requirements
Module: ps2_command_sequencer

---
 rtl/ps2_command_sequencer.sv | 150 +++++++++++++++
 tb/tb_ps2_command_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_command_sequencer.sv
// Keyboard line editor that commits typed command lines and issues a launch pulse on "FIRE".
// Edit buffer char 0 sits in the MSB byte so the buffer maps directly onto line_out.
module ps2_command_sequencer #(
  parameter int FIRE_HOLDOFF = 16,
  parameter int MAX_CHARS    = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   key_valid,
  input  logic [7:0]             key_ascii,
  input  logic                   launcher_busy,
  output logic [8*MAX_CHARS-1:0] line_out,
  output logic                   line_ready,
  output logic                   fire,
  output logic                   cmd_error,
  output logic [5:0]             char_count
);

  typedef enum logic [1:0] {COLLECT, DISPATCH, FIRE_WAIT, HOLDOFF} state_t;

  localparam int HW = (FIRE_HOLDOFF > 0) ? $clog2(FIRE_HOLDOFF + 1) : 1;
  localparam logic [5:0] MAXC = 6'(MAX_CHARS);
  localparam logic [8*MAX_CHARS-1:0] BLANK = {MAX_CHARS{8'h20}};

  state_t                          state_q, state_d;
  logic [0:MAX_CHARS-1][7:0]       buf_q, buf_d;
  logic [8*MAX_CHARS-1:0]          line_q, line_d;
  logic [5:0]                      count_q, count_d;
  logic                            ovf_q, ovf_d;
  logic [HW-1:0]                   hold_q, hold_d;
  logic                            line_ready_q, line_ready_d;
  logic                            fire_q, fire_d;
  logic                            cmd_error_q, cmd_error_d;

  logic       printable;
  logic [7:0] key_upper;
  logic       is_fire;

  assign printable = (key_ascii >= 8'h20) && (key_ascii <= 8'h7E);
  assign key_upper = ((key_ascii >= 8'h61) && (key_ascii <= 8'h7A)) ? key_ascii - 8'h20 : key_ascii;
  // Positions beyond the count are always blank, so the first four bytes plus the count decide it.
  assign is_fire   = (count_q == 6'd4) && (buf_q[0] == 8'h46) && (buf_q[1] == 8'h49) &&
                     (buf_q[2] == 8'h52) && (buf_q[3] == 8'h45);

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    line_d       = line_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    hold_d       = hold_q;
    line_ready_d = 1'b0;
    fire_d       = 1'b0;
    cmd_error_d  = 1'b0;

    case (state_q)
      COLLECT: begin
        if (key_valid) begin
          if (printable) begin
            if (count_q < MAXC) begin
              for (int i = 0; i < MAX_CHARS; i++) begin
                if (i == int'(count_q)) buf_d[i] = key_upper;
              end
              count_d = count_q + 6'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end else if (key_ascii == 8'h08) begin
            if (count_q != 6'd0) begin
              for (int i = 0; i < MAX_CHARS; i++) begin
                if (i == int'(count_q) - 1) buf_d[i] = 8'h20;
              end
              count_d = count_q - 6'd1;
            end
          end else if (key_ascii == 8'h0D) begin
            state_d = DISPATCH;
          end
        end
      end

      DISPATCH: begin
        buf_d   = BLANK;
        count_d = 6'd0;
        ovf_d   = 1'b0;
        state_d = COLLECT;
        if (ovf_q) begin
          cmd_error_d = 1'b1;
        end else if (count_q == 6'd0) begin
          state_d = COLLECT;
        end else if (is_fire) begin
          state_d = FIRE_WAIT;
        end else begin
          line_d       = buf_q;
          line_ready_d = 1'b1;
        end
      end

      FIRE_WAIT: begin
        if (!launcher_busy) begin
          fire_d  = 1'b1;
          hold_d  = HW'(FIRE_HOLDOFF);
          state_d = HOLDOFF;
        end
      end

      HOLDOFF: begin
        // A zero or one count both leave now, so a zero holdoff costs a single cycle.
        if (hold_q <= HW'(1)) begin
          hold_d  = '0;
          state_d = COLLECT;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end

      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= COLLECT;
      buf_q        <= BLANK;
      line_q       <= BLANK;
      count_q      <= 6'd0;
      ovf_q        <= 1'b0;
      hold_q       <= '0;
      line_ready_q <= 1'b0;
      fire_q       <= 1'b0;
      cmd_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      line_q       <= line_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      hold_q       <= hold_d;
      line_ready_q <= line_ready_d;
      fire_q       <= fire_d;
      cmd_error_q  <= cmd_error_d;
    end
  end

  assign line_out   = line_q;
  assign line_ready = line_ready_q;
  assign fire       = fire_q;
  assign cmd_error  = cmd_error_q;
  assign char_count = count_q;

endmodule

// File: tb/tb_ps2_command_sequencer.sv
// Directed self-checking bench for ps2_command_sequencer using immediate assertions.
module tb_ps2_command_sequencer;
  logic         clock;
  logic         reset;
  logic         key_valid;
  logic [7:0]   key_ascii;
  logic         launcher_busy;
  logic [255:0] line_out;
  logic         line_ready;
  logic         fire;
  logic         cmd_error;
  logic [5:0]   char_count;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [255:0] last_line;
  logic [255:0] blank_line;

  ps2_command_sequencer #(.FIRE_HOLDOFF(16), .MAX_CHARS(32)) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_ascii(key_ascii),
    .launcher_busy(launcher_busy), .line_out(line_out), .line_ready(line_ready),
    .fire(fire), .cmd_error(cmd_error), .char_count(char_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_key(input logic [7:0] c);
    key_valid = 1'b1;
    key_ascii = c;
    tick();
    key_valid = 1'b0;
    key_ascii = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_key(s[i]);
  endtask

  function automatic logic [255:0] pad(input string s);
    logic [255:0] r;
    r = {32{8'h20}};
    for (int i = 0; i < s.len(); i++) r[255-8*i -: 8] = s[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    blank_line    = {32{8'h20}};
    reset         = 1'b1;
    key_valid     = 1'b0;
    key_ascii     = 8'h00;
    launcher_busy = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_line", line_out, blank_line);
    chk("rst_count", char_count, 0);
    chk("rst_pulses", {line_ready, fire, cmd_error}, 0);

    // Basic commit with lowercase conversion
    send_str("set a 045");
    chk("a_count", char_count, 9);
    send_key(8'h0D);
    chk("a_no_early_ready", line_ready, 0);
    tick();
    chk("a_ready", line_ready, 1);
    chk("a_line", line_out, pad("SET A 045"));
    chk("a_count0", char_count, 0);
    chk("a_other", {fire, cmd_error}, 0);
    last_line = pad("SET A 045");
    tick();
    chk("a_ready_1cyc", line_ready, 0);
    chk("a_line_hold", line_out, last_line);

    // Empty Enter, keys sampled in DISPATCH are dropped
    send_key(8'h0D);
    send_key("A");
    chk("e_pulses", {line_ready, fire, cmd_error}, 0);
    chk("e_count", char_count, 0);
    send_key(8'h0D);
    send_key("B");
    chk("e_count2", char_count, 0);
    chk("e_line", line_out, last_line);

    // Backspace at zero and non-printable codes ignored
    send_key(8'h08);
    chk("bs_zero", char_count, 0);
    send_key(8'h09);
    send_key(8'h7F);
    chk("ignored", char_count, 0);

    // Editing with backspace
    send_str("SET V 1");
    chk("v_count7", char_count, 7);
    send_key(8'h08);
    send_key(8'h08);
    chk("v_count5", char_count, 5);
    send_str(" 99");
    chk("v_count8", char_count, 8);
    send_key(8'h0D);
    tick();
    chk("v_ready", line_ready, 1);
    chk("v_line", line_out, pad("SET V 99"));

    // Vacated position becomes blank
    send_str("ab");
    send_key(8'h08);
    send_key(8'h0D);
    tick();
    chk("bs_line", line_out, pad("A"));
    last_line = pad("A");

    // Overflow: 33 keys, count saturates, line rejected
    repeat (32) send_key(8'h5A);
    chk("ov_count32", char_count, 32);
    send_key(8'h5A);
    chk("ov_sat", char_count, 32);
    send_key(8'h0D);
    tick();
    chk("ov_err", cmd_error, 1);
    chk("ov_noready", line_ready, 0);
    chk("ov_line", line_out, last_line);
    chk("ov_count0", char_count, 0);
    tick();
    chk("ov_err_1cyc", cmd_error, 0);

    // Exactly full line is accepted
    repeat (32) send_key("q");
    chk("full_count", char_count, 32);
    send_key(8'h0D);
    tick();
    chk("full_ready", line_ready, 1);
    chk("full_line", line_out, {32{8'h51}});
    last_line = {32{8'h51}};

    // FIRE waits for the launcher, then holds off keys for 16 cycles
    launcher_busy = 1'b1;
    send_str("FIRE");
    send_key(8'h0D);
    for (int i = 0; i < 10; i++) begin
      send_key("K");
      chk("fw_busy_nofire", {fire, line_ready, cmd_error}, 0);
      chk("fw_count", char_count, 0);
    end
    launcher_busy = 1'b0;
    tick();
    chk("fw_fire", fire, 1);
    chk("fw_excl", {line_ready, cmd_error}, 0);
    chk("fw_line", line_out, last_line);
    for (int i = 0; i < 16; i++) begin
      send_key("X");
      chk("ho_drop", char_count, 0);
      chk("ho_fire_low", fire, 0);
    end
    send_key("X");
    chk("ho_accept", char_count, 1);
    send_key(8'h0D);
    tick();
    chk("ho_line", line_out, pad("X"));

    // Reset in FIRE_WAIT cancels fire; reset beats a same-cycle key
    launcher_busy = 1'b1;
    send_str("FIRE");
    send_key(8'h0D);
    tick();
    tick();
    reset         = 1'b1;
    launcher_busy = 1'b0;
    key_valid     = 1'b1;
    key_ascii     = "R";
    tick();
    reset     = 1'b0;
    key_valid = 1'b0;
    chk("rw_pulses", {fire, line_ready, cmd_error}, 0);
    chk("rw_line", line_out, blank_line);
    chk("rw_count", char_count, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rw_nofire", fire, 0);
    end
    send_str("fire");
    send_key(8'h0D);
    chk("rf_n", fire, 0);
    tick();
    chk("rf_n1", {fire, line_ready}, 0);
    tick();
    chk("rf_n2_fire", fire, 1);

    // Reset in HOLDOFF returns straight to COLLECT
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    send_key("Y");
    chk("rh_accept", char_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
